// File: rtl/arc_pkg.sv
// rtl/arc_pkg.sv - shared widths, reset vector and fetch packet type for the fetch front end
package arc_pkg;
    localparam int ADDR_W = 32;
    localparam int INSTR_W = 32;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pkt_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush; push into a full FIFO is accepted when a pop happens the same cycle
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
endmodule

// File: rtl/fetch_req_ctrl.sv
// rtl/fetch_req_ctrl.sv - PC owner and in-order instruction fetch requester with redirect and stale-response drop
module fetch_req_ctrl
    import arc_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_VECTOR,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic [31:0] o_req_addr,
    input  logic        i_rsp_valid,
    input  logic [31:0] i_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_addr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_addr_PC,
    output logic [31:0] o_data_Instr
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(MAX_OUTSTANDING + 1);

    logic          started_q;
    logic [31:0]   pc_q;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;

    logic          rsp_ok;
    logic          handshake;
    logic          keep_rsp;
    logic          buf_pop;

    logic [31:0]   tag_head;
    logic          tag_full;
    logic          tag_empty;
    logic [TW-1:0] tag_count;

    fetch_pkt_t    buf_in;
    fetch_pkt_t    buf_head;
    logic          buf_full;
    logic          buf_empty;
    logic [BW-1:0] buf_count;

    logic          unused_ok;

    // Credits count both in-flight requests and buffered pairs, so a response always has a slot.
    always_comb begin
        rsp_ok      = i_rsp_valid && (outstanding != '0);
        o_req_valid = started_q && !i_redirect_valid
                      && (int'(outstanding) < MAX_OUTSTANDING)
                      && ((int'(outstanding) + int'(buf_count)) < FIFO_DEPTH);
        handshake   = o_req_valid && i_req_ready;
        keep_rsp    = rsp_ok && (drop_cnt == '0) && !i_redirect_valid;
        buf_pop     = o_instr_valid && i_instr_ready;
        buf_in.pc    = tag_head;
        buf_in.instr = i_rsp_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            started_q   <= 1'b0;
            pc_q        <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            started_q   <= 1'b1;
            outstanding <= outstanding + CW'(handshake) - CW'(rsp_ok);
            if (i_redirect_valid) begin
                pc_q     <= {i_redirect_addr[31:2], 2'b00};
                // Every request still in flight belongs to a dead path, whatever epoch issued it.
                drop_cnt <= outstanding - CW'(rsp_ok);
            end else begin
                if (handshake) pc_q <= pc_q + 32'd4;
                if (rsp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (handshake),
        .push_data (pc_q),
        .pop       (keep_rsp),
        .flush     (i_redirect_valid),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_pkt_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_out_buf (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (keep_rsp),
        .push_data (buf_in),
        .pop       (buf_pop),
        .flush     (i_redirect_valid),
        .pop_data  (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign o_req_addr    = pc_q;
    assign o_instr_valid = !buf_empty;
    assign o_addr_PC     = buf_head.pc;
    assign o_data_Instr  = buf_head.instr;

    assign unused_ok = &{1'b0, tag_full, tag_empty, tag_count, buf_full, i_redirect_addr[1:0]};
endmodule

// File: tb/tb_fetch_req_ctrl.sv
// tb/tb_fetch_req_ctrl.sv - directed cycle-vector bench for fetch_req_ctrl
module tb_fetch_req_ctrl;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] addr_pc;
    logic [31:0] data_instr;

    int tests = 0;
    int fails = 0;
    int tb_out = 0;

    fetch_req_ctrl dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_req_valid      (req_valid),
        .i_req_ready      (req_ready),
        .o_req_addr       (req_addr),
        .i_rsp_valid      (rsp_valid),
        .i_rsp_data       (rsp_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_addr  (redirect_addr),
        .o_instr_valid    (instr_valid),
        .i_instr_ready    (instr_ready),
        .o_addr_PC        (addr_pc),
        .o_data_Instr     (data_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory side must never answer with nothing in flight.
    always @(posedge clk) begin
        if (!rst_n) tb_out <= 0;
        else begin
            if (rsp_valid && tb_out == 0) begin
                $display("FAIL protocol: response with no outstanding request");
                fails++;
            end
            tb_out <= tb_out + ((req_valid && req_ready) ? 1 : 0) - (rsp_valid ? 1 : 0);
        end
    end

    typedef struct {
        logic        rr;
        logic        rsp;
        logic [31:0] rdata;
        logic        redir;
        logic [31:0] raddr;
        logic        ir;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] I0 = 32'h2408_0001, I1 = 32'h2409_0002, I2 = 32'h240A_0003;
    localparam logic [31:0] I3 = 32'h240B_0004, I4 = 32'h240C_0005, J0 = 32'h3C01_0040;
    localparam logic [31:0] K0 = 32'h0800_0000, K1 = 32'h0000_0000 | 32'h1111_2222;
    localparam logic [31:0] S0 = 32'hDEAD_0000, S1 = 32'hDEAD_0001, S2 = 32'hDEAD_0002, S3 = 32'hDEAD_0003;

    task automatic add(input logic rr, input logic rsp, input logic [31:0] rdata,
                       input logic redir, input logic [31:0] raddr, input logic ir,
                       input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_pc, input logic [31:0] e_instr);
        vec_t v;
        v.rr = rr; v.rsp = rsp; v.rdata = rdata; v.redir = redir; v.raddr = raddr; v.ir = ir;
        v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc; v.e_instr = e_instr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rv, input logic [31:0] addr,
                           input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                           input logic cmp_data);
        chk({tag, " req_valid"}, 32'(req_valid), 32'(rv));
        chk({tag, " req_addr"}, req_addr, addr);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'(iv));
        if (cmp_data) begin
            chk({tag, " pc"}, addr_pc, pc);
            chk({tag, " instr"}, data_instr, instr);
        end
    endtask

    initial begin
        //   rr rsp rdata redir raddr          ir | rv addr          iv pc             instr
        add(1, 0, 0,  0, 0,             1,   0, 32'hBFC0_0000, 0, 0,             0);
        add(1, 0, 0,  0, 0,             1,   1, 32'hBFC0_0000, 0, 0,             0);
        add(1, 1, I0, 0, 0,             1,   1, 32'hBFC0_0004, 0, 0,             0);
        add(1, 1, I1, 0, 0,             1,   0, 32'hBFC0_0008, 1, 32'hBFC0_0000, I0);
        add(1, 0, 0,  0, 0,             1,   1, 32'hBFC0_0008, 1, 32'hBFC0_0004, I1);
        add(1, 1, I2, 0, 0,             1,   1, 32'hBFC0_000C, 0, 0,             0);
        add(1, 1, I3, 0, 0,             1,   0, 32'hBFC0_0010, 1, 32'hBFC0_0008, I2);
        add(1, 0, 0,  0, 0,             0,   1, 32'hBFC0_0010, 1, 32'hBFC0_000C, I3);
        add(1, 1, I4, 0, 0,             0,   0, 32'hBFC0_0014, 1, 32'hBFC0_000C, I3);
        add(1, 0, 0,  0, 0,             0,   0, 32'hBFC0_0014, 1, 32'hBFC0_000C, I3);
        add(1, 0, 0,  0, 0,             0,   0, 32'hBFC0_0014, 1, 32'hBFC0_000C, I3);
        add(1, 0, 0,  0, 0,             0,   0, 32'hBFC0_0014, 1, 32'hBFC0_000C, I3);
        add(1, 0, 0,  0, 0,             1,   0, 32'hBFC0_0014, 1, 32'hBFC0_000C, I3);
        add(1, 0, 0,  0, 0,             1,   1, 32'hBFC0_0014, 1, 32'hBFC0_0010, I4);
        add(1, 0, 0,  0, 0,             1,   1, 32'hBFC0_0018, 0, 0,             0);
        add(1, 0, 0,  1, 32'h0040_0003, 1,   0, 32'hBFC0_001C, 0, 0,             0);
        add(1, 1, S0, 0, 0,             1,   0, 32'h0040_0000, 0, 0,             0);
        add(1, 1, S1, 0, 0,             1,   1, 32'h0040_0000, 0, 0,             0);
        add(0, 1, J0, 0, 0,             1,   1, 32'h0040_0004, 0, 0,             0);
        add(1, 0, 0,  0, 0,             1,   1, 32'h0040_0004, 1, 32'h0040_0000, J0);
        add(1, 0, 0,  0, 0,             1,   1, 32'h0040_0008, 0, 0,             0);
        add(1, 1, S2, 1, 32'h0000_0100, 1,   0, 32'h0040_000C, 0, 0,             0);
        add(1, 0, 0,  1, 32'hFFFF_FFFD, 1,   0, 32'h0000_0100, 0, 0,             0);
        add(1, 1, S3, 0, 0,             1,   1, 32'hFFFF_FFFC, 0, 0,             0);
        add(0, 1, K0, 0, 0,             1,   1, 32'h0000_0000, 0, 0,             0);
        add(1, 0, 0,  0, 0,             0,   1, 32'h0000_0000, 1, 32'hFFFF_FFFC, K0);
        add(1, 1, K1, 0, 0,             0,   0, 32'h0000_0004, 1, 32'hFFFF_FFFC, K0);
        add(1, 0, 0,  0, 0,             0,   0, 32'h0000_0004, 1, 32'hFFFF_FFFC, K0);

        rst_n = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        redirect_valid = 1'b0; redirect_addr = '0; instr_ready = 1'b0;

        @(negedge clk);
        #2;
        chk_out("reset", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            req_ready      = vecs[i].rr;
            rsp_valid      = vecs[i].rsp;
            rsp_data       = vecs[i].rdata;
            redirect_valid = vecs[i].redir;
            redirect_addr  = vecs[i].raddr;
            instr_ready    = vecs[i].ir;
            #1;
            chk_out($sformatf("row%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_iv,
                    vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_iv);
            @(negedge clk);
        end

        // Mid-stream reset with a full output buffer: outputs clear without waiting for a clock.
        req_ready = 1'b0; rsp_valid = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("midreset", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        req_ready = 1'b1; instr_ready = 1'b1;
        #1;
        chk_out("release", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        chk_out("restart0", 1'b1, 32'hBFC0_0000, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rsp_valid = 1'b1; rsp_data = 32'hCAFE_F00D;
        #1;
        chk_out("restart1", 1'b1, 32'hBFC0_0004, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rsp_valid = 1'b0; req_ready = 1'b0; instr_ready = 1'b0;
        #1;
        chk_out("restart2", 1'b0, 32'hBFC0_0008, 1'b1, 32'hBFC0_0000, 32'hCAFE_F00D, 1'b1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
